matrix_scan_driver: RTL and testbench

Reads a 16x16 glyph from the team's combinational glyph ROM one pixel per cycle by driving row/column addresses and a glyph select. It assembles each row into a 16-bit buffer, then drives a row-multiplexed 16x16 LED dot matrix. Each row is held for a programmable dwell time. The block sits between the ROM and the board's LED matrix pins.

---
 rtl/matrix_scan_driver.sv | 120 ++++++++++++
 tb/tb_matrix_scan_driver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : matrix_scan_driver
// Brief    : Fetches a 16x16 glyph from a combinational ROM one pixel per
//            cycle and drives a row-multiplexed LED matrix with a row dwell.
// Revision : 1.0
// ============================================================================
module matrix_scan_driver #(
  parameter int DWELL   = 1000,
  parameter int DWELL_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  select,
  input  logic        pixel,
  output logic [3:0]  row_addr,
  output logic [3:0]  col_addr,
  output logic [1:0]  glyph_sel,
  output logic [15:0] led_row,
  output logic [15:0] led_col,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [DWELL_W-1:0] c_dwell_last = DWELL_W'(DWELL - 1);

  state_t             r_state;
  logic [3:0]         r_row_addr;
  logic [3:0]         r_col_addr;
  logic [1:0]         r_glyph_sel;
  logic [15:0]        r_led_row;
  logic [15:0]        r_led_col;
  logic               r_frame_done;
  logic [15:0]        r_buf;
  logic [DWELL_W-1:0] r_dwell;

  logic [15:0]        w_row_full;
  logic [15:0]        w_row_onehot;

  // The last pixel of a row lands in bit 0 on the same edge the row is latched.
  assign w_row_full   = {r_buf[15:1], pixel};
  assign w_row_onehot = 16'b1 << r_row_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_row_addr   <= 4'd0;
      r_col_addr   <= 4'd0;
      r_glyph_sel  <= 2'd0;
      r_led_row    <= 16'd0;
      r_led_col    <= 16'd0;
      r_frame_done <= 1'b0;
      r_buf        <= 16'd0;
      r_dwell      <= '0;
    end else if (!enable) begin
      r_state      <= IDLE;
      r_row_addr   <= 4'd0;
      r_col_addr   <= 4'd0;
      r_led_row    <= 16'd0;
      r_led_col    <= 16'd0;
      r_frame_done <= 1'b0;
      r_dwell      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_glyph_sel  <= select;
          r_row_addr   <= 4'd0;
          r_col_addr   <= 4'd0;
          r_led_row    <= 16'd0;
          r_frame_done <= 1'b0;
          r_state      <= FETCH;
        end
        FETCH: begin
          r_frame_done               <= 1'b0;
          r_buf[4'd15 - r_col_addr]  <= pixel;
          r_col_addr                 <= r_col_addr + 4'd1;
          if (r_col_addr == 4'd15) begin
            r_led_col <= w_row_full;
            r_led_row <= w_row_onehot;
            r_dwell   <= '0;
            r_state   <= SHOW;
          end
        end
        SHOW: begin
          if (r_dwell == c_dwell_last) begin
            r_led_row <= 16'd0;
            r_dwell   <= '0;
            r_state   <= FETCH;
            if (r_row_addr == 4'd15) begin
              // Frame boundary: the only point where a new glyph is adopted.
              r_row_addr   <= 4'd0;
              r_frame_done <= 1'b1;
              r_glyph_sel  <= select;
            end else begin
              r_row_addr <= r_row_addr + 4'd1;
            end
          end else begin
            r_dwell <= r_dwell + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign row_addr   = r_row_addr;
  assign col_addr   = r_col_addr;
  assign glyph_sel  = r_glyph_sel;
  assign led_row    = r_led_row;
  assign led_col    = r_led_col;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_scan_driver
// Brief    : Randomized bench for matrix_scan_driver against a timing-position
//            reference model (position within frame -> expected outputs).
// Revision : 1.0
// ============================================================================
module tb_matrix_scan_driver;

  localparam int c_DWELL = 4;
  localparam int c_P     = 16 + c_DWELL;
  localparam int c_F     = 16 * c_P;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [1:0]  select;
  logic        pixel;
  logic [3:0]  row_addr;
  logic [3:0]  col_addr;
  logic [1:0]  glyph_sel;
  logic [15:0] led_row;
  logic [15:0] led_col;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  matrix_scan_driver #(.DWELL(c_DWELL), .DWELL_W(3)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .select     (select),
    .pixel      (pixel),
    .row_addr   (row_addr),
    .col_addr   (col_addr),
    .glyph_sel  (glyph_sel),
    .led_row    (led_row),
    .led_col    (led_col),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] c_g1 [16] = '{16'h0000, 16'h03C0, 16'h0FF0, 16'h1FF8,
                             16'h3FFC, 16'h3FFC, 16'h7FFE, 16'h7FFE,
                             16'h7FFE, 16'h7FFE, 16'h3FFC, 16'h3FFC,
                             16'h1FF8, 16'h3FFC, 16'h03C0, 16'h0000};
  logic [15:0] c_g2 [16] = '{16'h0000, 16'hE007, 16'hF00F, 16'h781E,
                             16'h3C3C, 16'h1E78, 16'h0FF0, 16'h07E0,
                             16'h07E0, 16'h0FF0, 16'h1E78, 16'h3C3C,
                             16'h781E, 16'hF00F, 16'hE007, 16'h0000};

  // Pixel-level ROM seen by the DUT; column 0 is the leftmost (MSB) pixel.
  function automatic logic rom_pixel(input logic [1:0] g, input logic [3:0] r,
                                     input logic [3:0] c);
    logic [15:0] w;
    case (g)
      2'd1:    begin w = c_g1[r]; return w[4'd15 - c]; end
      2'd2:    begin w = c_g2[r]; return w[4'd15 - c]; end
      2'd3:    return r[0] ^ c[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] rom_row(input logic [1:0] g, input int r);
    case (g)
      2'd1:    return c_g1[r];
      2'd2:    return c_g2[r];
      2'd3:    return (r % 2 == 0) ? 16'h5555 : 16'hAAAA;
      default: return 16'h0000;
    endcase
  endfunction

  always_comb pixel = rom_pixel(glyph_sel, row_addr, col_addr);

  // Reference model: scanning position within the frame.
  logic        m_active;
  int          m_p;
  logic [1:0]  m_glyph;
  logic [15:0] m_ledcol;
  logic        m_fd;

  task automatic model_reset();
    m_active = 1'b0; m_p = 0; m_glyph = 2'd0; m_ledcol = 16'd0; m_fd = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic [1:0] sel);
    if (!en) begin
      m_active = 1'b0; m_p = 0; m_ledcol = 16'd0; m_fd = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1; m_p = 0; m_glyph = sel; m_fd = 1'b0;
    end else begin
      m_fd = 1'b0;
      m_p  = m_p + 1;
      if (m_p == c_F) begin
        m_p = 0; m_fd = 1'b1; m_glyph = sel;
      end
      if (m_p % c_P == 16) m_ledcol = rom_row(m_glyph, m_p / c_P);
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    int row, ph;
    row = m_p / c_P;
    ph  = m_p % c_P;
    check_eq("glyph_sel", 32'(glyph_sel), 32'(m_glyph));
    check_eq("frame_done", 32'(frame_done), 32'(m_fd));
    check_eq("led_col", 32'(led_col), 32'(m_ledcol));
    check_eq("row_onehot", 32'($countones(led_row) <= 1), 32'd1);
    if (!m_active) begin
      check_eq("idle_row_addr", 32'(row_addr), 32'd0);
      check_eq("idle_col_addr", 32'(col_addr), 32'd0);
      check_eq("idle_led_row", 32'(led_row), 32'd0);
    end else begin
      check_eq("row_addr", 32'(row_addr), 32'(row));
      check_eq("col_addr", 32'(col_addr), (ph < 16) ? 32'(ph) : 32'd0);
      check_eq("led_row", 32'(led_row), (ph < 16) ? 32'd0 : (32'd1 << row));
    end
  endtask

  task automatic cycle(input logic en, input logic [1:0] sel);
    @(negedge clk);
    compare_all();
    enable = en;
    select = sel;
    model_step(en, sel);
  endtask

  task automatic run_until_pos(input int row, input int ph, input logic [1:0] sel);
    int budget = 2 * c_F;
    while (!(m_active && (m_p / c_P == row) && (m_p % c_P == ph)) && budget > 0) begin
      cycle(1'b1, sel);
      budget--;
    end
    if (budget == 0) check_eq("wait_budget", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    select = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 2'd0);

    // Async reset in the middle of a lit row.
    run_until_pos(3, 18, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_led_row", 32'(led_row), 32'd0);
    check_eq("rst_led_col", 32'(led_col), 32'd0);
    check_eq("rst_row_addr", 32'(row_addr), 32'd0);
    check_eq("rst_col_addr", 32'(col_addr), 32'd0);
    check_eq("rst_glyph_sel", 32'(glyph_sel), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    model_reset();
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cycle(1'b0, 2'd1);

    // Glyph 2 for a full frame, then glyph 1 with a mid-frame change to 2.
    repeat (c_F + 30) cycle(1'b1, 2'd2);
    run_until_pos(0, 1, 2'd1);
    run_until_pos(7, 10, 2'd1);
    repeat (c_F + 40) cycle(1'b1, 2'd2);

    // Checkerboard glyph exposes column bit ordering.
    repeat (c_F + 20) cycle(1'b1, 2'd3);
    run_until_pos(0, 2, 2'd3);
    repeat (c_F) cycle(1'b1, 2'd3);

    // Enable drop during FETCH of row 5, then restart.
    run_until_pos(5, 7, 2'd1);
    repeat (2) cycle(1'b0, 2'd1);
    repeat (c_P * 3) cycle(1'b1, 2'd1);

    // Randomized enable/select activity.
    begin
      logic       en;
      logic [1:0] sel;
      en  = 1'b1;
      sel = 2'($urandom_range(0, 3));
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 40) == 0) sel = 2'($urandom_range(0, 3));
        en = ($urandom_range(0, 250) != 0);
        cycle(en, sel);
      end
    end
    cycle(1'b1, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
